// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32 instruction fetch path.
package rv32_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_RUN   = 2'd0,
      FETCH_DRAIN = 2'd1,
      FETCH_HALT  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            err;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/rv32_mod_instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory port plus the decode-side instruction stream.
interface rv32_mod_instruction_fetch_if;
   import rv32_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [ILEN-1:0] imem_rdata;
   logic            imem_err;

   logic            instr_valid;
   logic [ILEN-1:0] instr;
   logic [XLEN-1:0] instr_pc;
   logic            instr_err;
   logic            instr_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata, imem_err,
      output instr_valid, instr, instr_pc, instr_err,
      input  instr_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata, imem_err,
      input  instr_valid, instr, instr_pc, instr_err,
      output instr_ready
   );

endinterface

// File: rtl/rv32_mod_fetch_fifo.sv
// Prefetch FIFO of {pc, instr, err}; supports push+pop at full and a flush that wins over both.
module rv32_mod_fetch_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  fetch_entry_t               din,
   input  logic                       pop,
   input  logic                       flush,
   output fetch_entry_t               dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push_ok;
   logic            pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/rv32_mod_instruction_fetch.sv
// rv32imc instruction fetch: owns the fetch PC, one outstanding imem request, prefetch FIFO.
// Optional RV32_FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch and raise fetch_misaligned.
//
// state       | meaning
// FETCH_RUN   | issue requests while FIFO + outstanding has room
// FETCH_DRAIN | redirect hit an open request; hold it, drop its response
// FETCH_HALT  | stopped after a bus error or misaligned target
module rv32_mod_instruction_fetch
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   rv32_mod_instruction_fetch_if.master bus,
   input  logic                         redirect,
   input  logic [XLEN-1:0]              redirect_pc
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
   ,
   output logic                         fetch_misaligned
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e    state;
   fetch_state_e    state_next;
   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] fpc_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   cnt_next;
   logic            full;
   logic            empty;
   logic            ack;
   logic            pop;
   logic            push;
   logic            misaligned;
   fetch_entry_t    head;
   fetch_entry_t    entry;

   assign entry = '{pc: fpc, instr: bus.imem_rdata, err: bus.imem_err};

   rv32_mod_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push & (~full | pop)),
      .din   (entry),
      .pop   (pop),
      .flush (redirect),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign bus.instr_valid = ~empty;
   assign bus.instr       = head.instr;
   assign bus.instr_pc    = head.pc;
   assign bus.instr_err   = head.err;

   always_comb begin
      ack        = bus.imem_req & bus.imem_ack;
      pop        = ~empty & bus.instr_ready;
      push       = ack & (state == FETCH_RUN) & ~redirect;
      misaligned = 1'b0;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
      misaligned = (redirect_pc[1:0] != 2'b00);
`endif
      fpc_next = fpc;
      if (redirect)  fpc_next = word_align(redirect_pc);
      else if (push) fpc_next = fpc + XLEN'(4);
      cnt_next = redirect ? '0 : count + CW'(push) - CW'(pop);

      state_next = state;
      if (redirect) begin
         if (misaligned)                        state_next = FETCH_HALT;
         else if (bus.imem_req & ~bus.imem_ack) state_next = FETCH_DRAIN;
         else                                   state_next = FETCH_RUN;
      end else if (ack) begin
         if (state == FETCH_DRAIN)                       state_next = FETCH_RUN;
         else if (state == FETCH_RUN && bus.imem_err)    state_next = FETCH_HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= FETCH_RUN;
         fpc           <= RESET_PC;
         bus.imem_req  <= 1'b0;
         bus.imem_addr <= RESET_PC;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
         fetch_misaligned <= 1'b0;
`endif
      end else begin
         state <= state_next;
         fpc   <= fpc_next;
         // An open request is never withdrawn; only re-decide once it completes.
         if (ack | ~bus.imem_req) begin
            bus.imem_req  <= (state_next == FETCH_RUN) && (cnt_next < CW'(FIFO_DEPTH));
            bus.imem_addr <= fpc_next;
         end
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
         if (redirect) fetch_misaligned <= misaligned;
`endif
      end
   end

endmodule

// File: tb/tb_rv32_mod_instruction_fetch.sv
// Bench for rv32_mod_instruction_fetch: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_rv32_mod_instruction_fetch;
   localparam int          DEPTH = 2;
   localparam logic [31:0] PAT   = 32'hA5A5_A5A5;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
   logic        fetch_misaligned;
`endif

   rv32_mod_instruction_fetch_if bus();

   rv32_mod_instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: fixed or random wait, data pattern or random, optional errors.
   int          mem_wait  = 0;
   int          err_mode  = 0;
   logic [31:0] err_addr  = 32'h0;
   bit          rand_data = 1'b0;

   initial begin
      int wc;
      int cur_wait;
      wc = 0;
      cur_wait = 0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.imem_err   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!bus.imem_req) begin
            bus.imem_ack = 1'b0;
            bus.imem_err = 1'b0;
            wc = 0;
         end else begin
            if (wc == 0) cur_wait = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
            if (wc >= cur_wait) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = rand_data ? $urandom : (bus.imem_addr ^ PAT);
               bus.imem_err   = (err_mode == 1) ? (bus.imem_addr == err_addr) :
                                (err_mode == 2) ? ($urandom_range(0, 31) == 0) : 1'b0;
               wc = 0;
            end else begin
               bus.imem_ack = 1'b0;
               bus.imem_err = 1'b0;
               wc++;
            end
         end
      end
   end

   // Transaction-level model: expected FIFO contents, next fetch address, request expectation.
   ent_t        exp_q[$];
   logic [31:0] m_fpc  = 32'h0;
   logic [31:0] m_addr = 32'h0;
   bit          m_req = 0, m_halt = 0, m_stale = 0, m_mis = 0, model_ok = 0;

   always @(negedge clk) begin
      if (model_ok) begin
         chk("imem_req", 32'(bus.imem_req), 32'(m_req));
         if (m_req) chk("imem_addr", bus.imem_addr, m_addr);
         chk("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            chk("instr_pc", bus.instr_pc, exp_q[0].pc);
            chk("instr", bus.instr, exp_q[0].instr);
            chk("instr_err", 32'(bus.instr_err), 32'(exp_q[0].err));
         end
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
         chk("fetch_misaligned", 32'(fetch_misaligned), 32'(m_mis));
`endif
      end
      if (!rst_n) begin
         exp_q.delete();
         m_fpc = 32'h0; m_addr = 32'h0;
         m_req = 0; m_halt = 0; m_stale = 0; m_mis = 0;
         model_ok = 1;
      end else if (model_ok) begin
         if (redirect) begin
            exp_q.delete();
            m_fpc = redirect_pc & ~32'h3;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
            m_mis = (redirect_pc[1:0] != 2'b00);
`endif
            m_halt  = m_mis;
            m_stale = m_req && !bus.imem_ack;
         end else begin
            if (exp_q.size() > 0 && bus.instr_ready) void'(exp_q.pop_front());
            if (m_req && bus.imem_ack) begin
               if (m_stale) m_stale = 0;
               else begin
                  exp_q.push_back('{pc: m_fpc, instr: bus.imem_rdata, err: bus.imem_err});
                  m_fpc = m_fpc + 32'd4;
                  if (bus.imem_err) m_halt = 1;
               end
            end
         end
         if (!(m_req && !bus.imem_ack)) begin
            m_req = !m_halt && (exp_q.size() < DEPTH);
            if (m_req) m_addr = m_fpc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      int reqs;
      bit found;

      // Reset values, then zero-wait streaming with instr_ready=1.
      bus.instr_ready = 1'b1;
      do_reset();
      #1;
      chk("rst_req", 32'(bus.imem_req), 32'h0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_pc", bus.instr_pc, 32'h0);
      chk("rst_err", 32'(bus.instr_err), 32'h0);
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
      chk("rst_mis", 32'(fetch_misaligned), 32'h0);
`endif
      step(); #1;
      chk("t1_req_c1", 32'(bus.imem_req), 32'h1);
      chk("t1_addr_c1", bus.imem_addr, 32'h0);
      step(); #1;
      chk("t1_addr_c2", bus.imem_addr, 32'h4);
      chk("t1_valid_c2", 32'(bus.instr_valid), 32'h1);
      chk("t1_pc_c2", bus.instr_pc, 32'h0);
      chk("t1_instr_c2", bus.instr, 32'hA5A5_A5A5);
      step(); #1;
      chk("t1_addr_c3", bus.imem_addr, 32'h8);
      chk("t1_pc_c3", bus.instr_pc, 32'h4);
      chk("t1_instr_c3", bus.instr, 32'hA5A5_A5A1);

      // Back-pressure: only FIFO_DEPTH responses accepted, then in-order drain.
      bus.instr_ready = 1'b0;
      do_reset();
      acks = 0;
      repeat (10) begin
         step(); #1;
         if (bus.imem_req && bus.imem_ack) acks++;
      end
      chk("t2_acks", 32'(acks), 32'd2);
      chk("t2_req_idle", 32'(bus.imem_req), 32'h0);
      step();
      bus.instr_ready = 1'b1;
      #1;
      chk("t2_head0", bus.instr_pc, 32'h0);
      step(); #1;
      chk("t2_head1", bus.instr_pc, 32'h4);

      // Redirect while a slow request is open: old response dropped.
      mem_wait = 3;
      do_reset();
      step();
      step();
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      #1;
      chk("t3_hold_req", 32'(bus.imem_req), 32'h1);
      chk("t3_hold_addr", bus.imem_addr, 32'h0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(); #1;
         if (bus.imem_req && bus.imem_addr == 32'h100) found = 1;
      end
      chk("t3_target_req", 32'(found), 32'h1);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.instr_valid) found = 1;
         else begin step(); #1; end
      end
      chk("t3_delivered", 32'(found), 32'h1);
      chk("t3_first_pc", bus.instr_pc, 32'h100);
      chk("t3_first_instr", bus.instr, 32'hA5A5_A4A5);

      // Redirect coincident with the ack of 0x8.
      mem_wait = 0;
      do_reset();
      step();
      step();
      step();
      redirect = 1'b1; redirect_pc = 32'h200;
      #1;
      chk("t4_ack_addr", bus.imem_addr, 32'h8);
      chk("t4_ack", 32'(bus.imem_ack), 32'h1);
      step();
      redirect = 1'b0;
      #1;
      chk("t4_req", 32'(bus.imem_req), 32'h1);
      chk("t4_addr", bus.imem_addr, 32'h200);
      chk("t4_flushed", 32'(bus.instr_valid), 32'h0);
      step(); #1;
      chk("t4_valid", 32'(bus.instr_valid), 32'h1);
      chk("t4_pc", bus.instr_pc, 32'h200);

      // Bus error on 0xC halts fetch until a redirect.
      err_mode = 1; err_addr = 32'hC;
      do_reset();
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(); #1;
         if (bus.instr_valid && bus.instr_pc == 32'hC) found = 1;
      end
      chk("t5_err_entry", 32'(found), 32'h1);
      chk("t5_instr_err", 32'(bus.instr_err), 32'h1);
      reqs = 0;
      repeat (4) begin
         step(); #1;
         if (bus.imem_req) reqs++;
      end
      chk("t5_halted", 32'(reqs), 32'h0);
      err_mode = 0;
      redirect = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      #1;
      chk("t5_resume_req", 32'(bus.imem_req), 32'h1);
      chk("t5_resume_addr", bus.imem_addr, 32'h40);

      // Misaligned redirect target.
      redirect = 1'b1; redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
      #1;
`ifdef RV32_FETCH_MISALIGN_TRAP_EN
      chk("t6_mis_set", 32'(fetch_misaligned), 32'h1);
      chk("t6_no_req", 32'(bus.imem_req), 32'h0);
      step(); #1;
      chk("t6_still_no_req", 32'(bus.imem_req), 32'h0);
      redirect = 1'b1; redirect_pc = 32'h104;
      step();
      redirect = 1'b0;
      #1;
      chk("t6_mis_clr", 32'(fetch_misaligned), 32'h0);
      chk("t6_req", 32'(bus.imem_req), 32'h1);
      chk("t6_addr", bus.imem_addr, 32'h104);
`else
      chk("t6_req", 32'(bus.imem_req), 32'h1);
      chk("t6_addr", bus.imem_addr, 32'h100);
`endif

      // Randomized traffic: waits, back-pressure, redirects, errors, wrap, resets.
      mem_wait = -1; err_mode = 2; rand_data = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         step();
         rst_n = ($urandom_range(0, 999) != 0);
         bus.instr_ready = ($urandom_range(0, 3) != 0);
         if (!redirect && $urandom_range(0, 24) == 0) begin
            redirect = 1'b1;
            if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF8;
            else begin
               redirect_pc = 32'($urandom_range(0, 255)) << 2;
               if ($urandom_range(0, 5) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            end
         end else begin
            redirect = 1'b0;
         end
      end
      step();
      rst_n = 1'b1;
      redirect = 1'b0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32_mod_instruction_fetch.md
# rv32_mod_instruction_fetch

Instruction fetch unit for the rv32imc single-stage core. It produces the instruction stream the instruction decoder consumes. It owns the fetch PC and issues word requests on the instruction-memory port, buffering responses in a small prefetch FIFO. It presents {instr, pc, err} to the decode stage with a valid/ready handshake, and flushes and re-targets on a redirect from branch/jump resolution.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2.

Ports:
- clk  in  1  core clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word address; bits[1:0] always 0.
- imem_ack  in  1  response/transfer complete; valid only while imem_req=1.
- imem_rdata  in  32  fetched word; valid with imem_ack.
- imem_err  in  1  bus error; valid with imem_ack.
- instr_valid  out  1  FIFO head valid.
- instr  out  32  instruction word.
- instr_pc  out  32  address of instr.
- instr_err  out  1  fetch error on this entry.
- instr_ready  in  1  decoder accepts head.
- redirect  in  1  taken branch/jump; one-cycle pulse.
- redirect_pc  in  32  new fetch target.
- fetch_misaligned  out  1  present only with RV32_FETCH_MISALIGN_TRAP_EN.

## Operation
- Registers: fpc (next fetch address), FIFO of {pc, instr, err}, count, state.
- States:
  - RUN: issue requests.
  - DRAIN: wait out a stale outstanding request after a redirect.
  - HALT: stopped after an error.
- At most one request outstanding. Once imem_req rises, imem_req and imem_addr stay stable until imem_ack.
- RUN raises imem_req only when count + outstanding < FIFO_DEPTH. Full FIFO never drops a response.
- Ack in RUN without redirect:
  - push {fpc, imem_rdata, imem_err}; fpc += 4 (32-bit wrap, 0xFFFF_FFFC → 0).
  - If imem_err: push, then go to HALT (imem_req=0).
- Pop when instr_valid & instr_ready.
- Push and pop in the same cycle are both legal, including at full.
- Redirect, any state:
  - flush FIFO (count=0, instr_valid=0 next cycle);
  - fpc ← redirect_pc with bits[1:0] cleared.
- After a redirect:
  - Unacked request still open, no ack this cycle: go to DRAIN. Keep req/addr until ack, discard that response, then go to RUN.
  - Ack in the same cycle as redirect: discard the data, go to RUN.
- Redirect in HALT: resume RUN at the target.
- Redirect in DRAIN: update fpc, stay in DRAIN.
- Pop concurrent with redirect: the pop is legal, but the flush wins.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0, instr_err=0.
  - fetch_misaligned=0.
  - fpc=RESET_PC, state=RUN, count=0.
- First imem_req=1 in the first cycle after rst_n deasserts.
- Ack at cycle N: entry visible at instr_valid in cycle N+1.
- With a zero-wait memory (ack in the same cycle as req), the next request may issue at N+1.
- Sustained throughput is 1 instr/cycle with zero-wait memory and instr_ready=1.
- Redirect at cycle N:
  - instr_valid=0 at N+1;
  - request to the target at N+1, unless draining.
- Reset mid-transaction: everything returns to reset values. A pending ack after reset is ignored because imem_req=0.

## Configuration
- RV32_FETCH_MISALIGN_TRAP_EN defined:
  - redirect_pc[1:0]≠0 flushes, sets fetch_misaligned=1 and enters HALT without requesting.
  - fetch_misaligned clears on the next aligned redirect or on reset.
- Undefined:
  - port absent;
  - redirect_pc[1:0] silently forced to 0.

## Structure
- Shared package rv32_pkg:
  - fetch state typedef (RUN/DRAIN/HALT);
  - XLEN=32, ILEN=32 constants;
  - default reset-vector constant.
- Sub-module rv32_mod_fetch_fifo:
  - synchronous FIFO, width 65;
  - push/pop/flush/count/full/empty;
  - same-cycle push+pop at full.

## Test plan
- Reset, zero-wait memory returning addr^32'hA5A5_A5A5, instr_ready=1:
  - req at cycle 1, addr 0,4,8…;
  - instr_valid from cycle 2, instr_pc tracks addr.
- instr_ready=0 for 10 cycles, FIFO_DEPTH=2:
  - exactly 2 acks accepted; imem_req deasserts, never aborted;
  - ready=1 drains in order pc 0,4.
- Ack delayed 3 cycles; redirect to 0x100 on cycle after req:
  - response for the old addr discarded;
  - next req addr=0x100; first delivered instr_pc=0x100.
- Redirect to 0x200 in the same cycle as ack of 0x8:
  - 0x8 never delivered;
  - req 0x200 next cycle.
- imem_err on fetch of 0xC:
  - entry delivered with instr_err=1; no further req;
  - redirect to 0x40 resumes.
- Macro on: redirect_pc=0x102 → fetch_misaligned=1, no req. Then redirect 0x104 → cleared, fetch 0x104.
- Macro off: same stimulus fetches 0x100.
